// File: rtl/wn_phase_comp_sched_pkg.sv
// ----------------------------------------------------------------------------
// wn_phase_comp_sched_pkg
// Shared types and default sizes for the two-channel phase-compensation
// scheduler: FSM state encoding, channel tag type, default widths/depth.
// ----------------------------------------------------------------------------
package wn_phase_comp_sched_pkg;

  localparam int unsigned DATA_W_DEF    = 32;  // imag[31:16], real[15:0]
  localparam int unsigned SLOT_W_DEF    = 8;
  localparam int unsigned TAG_DEPTH_DEF = 4;   // power of 2, >= 2

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    DATA = 2'd2
  } sched_state_e;

  // Channel tag carried through the datapath: 0 = channel 0, 1 = channel 1.
  typedef logic chan_t;

endpackage

// File: rtl/wn_phase_comp_tag_fifo.sv
// ----------------------------------------------------------------------------
// wn_phase_comp_tag_fifo
// Synchronous FIFO of channel tags, one entry per packet in flight inside the
// shared datapath. Full/empty come from an occupancy counter so that a
// simultaneous push and pop leaves occupancy unchanged.
//
// Ports:
//   clock, reset_n   clock / asynchronous active-low reset (FIFO cleared)
//   push, push_tag   enqueue a tag (ignored when full)
//   pop              dequeue the head tag (ignored when empty)
//   head_tag         tag at the head of the FIFO (valid when !empty)
//   full, empty      occupancy flags
// ----------------------------------------------------------------------------
module wn_phase_comp_tag_fifo
  import wn_phase_comp_sched_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  push,
  input  chan_t push_tag,
  input  logic  pop,
  output chan_t head_tag,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  chan_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = mem[rd_ptr];

  // NOTE: storage is deliberately left out of the reset; an entry is only
  // ever read after it has been written, so clearing it buys nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wn_phase_comp_scheduler.sv
// ----------------------------------------------------------------------------
// wn_phase_comp_scheduler
// Shares one phase-compensation datapath between two antenna streams.
// Round-robin arbitration per symbol packet: the granted channel's slot number
// is forwarded, then its samples pass straight through (zero latency) until
// tlast. A tag FIFO remembers the owner of each packet in flight so the
// datapath's output packets are steered back to the right channel.
//
// Optional feature (macro PHC_SCHED_PKT_CNT_EN): adds pkt_cnt_0/pkt_cnt_1
// (output packets per channel) and drop_cnt (spurious datapath outputs).
//
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   slot_num_in_N_*                 per-channel slot number stream (N = 0, 1)
//   data_in_N_*                     per-channel input samples
//   dp_slot_*                       slot number to the datapath
//   dp_in_*                         samples to the datapath
//   dp_out_*                        compensated samples from the datapath
//   data_out_N_*                    per-channel output samples
//   grant_ch                        channel owning the input side
//   busy                            FSM not IDLE or packets in flight
//   tag_err                         sticky: datapath output with no tag
// ----------------------------------------------------------------------------
module wn_phase_comp_scheduler
  import wn_phase_comp_sched_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned SLOT_W    = SLOT_W_DEF,
  parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [SLOT_W-1:0] slot_num_in_0_tdata,
  input  logic              slot_num_in_0_tvalid,
  output logic              slot_num_in_0_tready,
  input  logic [DATA_W-1:0] data_in_0_tdata,
  input  logic              data_in_0_tlast,
  input  logic              data_in_0_tvalid,
  output logic              data_in_0_tready,
  input  logic [SLOT_W-1:0] slot_num_in_1_tdata,
  input  logic              slot_num_in_1_tvalid,
  output logic              slot_num_in_1_tready,
  input  logic [DATA_W-1:0] data_in_1_tdata,
  input  logic              data_in_1_tlast,
  input  logic              data_in_1_tvalid,
  output logic              data_in_1_tready,
  output logic [SLOT_W-1:0] dp_slot_tdata,
  output logic              dp_slot_tvalid,
  input  logic              dp_slot_tready,
  output logic [DATA_W-1:0] dp_in_tdata,
  output logic              dp_in_tlast,
  output logic              dp_in_tvalid,
  input  logic              dp_in_tready,
  input  logic [DATA_W-1:0] dp_out_tdata,
  input  logic              dp_out_tlast,
  input  logic              dp_out_tvalid,
  output logic              dp_out_tready,
  output logic [DATA_W-1:0] data_out_0_tdata,
  output logic              data_out_0_tlast,
  output logic              data_out_0_tvalid,
  input  logic              data_out_0_tready,
  output logic [DATA_W-1:0] data_out_1_tdata,
  output logic              data_out_1_tlast,
  output logic              data_out_1_tvalid,
  input  logic              data_out_1_tready,
  output chan_t             grant_ch,
  output logic              busy,
  output logic              tag_err
`ifdef PHC_SCHED_PKT_CNT_EN
  ,
  output logic [15:0]       pkt_cnt_0,
  output logic [15:0]       pkt_cnt_1,
  output logic [15:0]       drop_cnt
`endif
);

  sched_state_e state;
  chan_t        last_grant;
  chan_t        next_grant;
  logic         any_req;

  logic [SLOT_W-1:0] g_slot_tdata;
  logic              g_slot_tvalid;
  logic [DATA_W-1:0] g_data_tdata;
  logic              g_data_tlast;
  logic              g_data_tvalid;

  logic  slot_hs;
  logic  data_last_hs;
  logic  tag_pop;
  logic  tag_err_set;
  chan_t head_tag;
  logic  fifo_full;
  logic  fifo_empty;

  // --------------------------------------------------------------------------
  // Arbitration: on a tie the channel that did not own the last packet wins.
  // --------------------------------------------------------------------------
  assign any_req    = slot_num_in_0_tvalid || slot_num_in_1_tvalid;
  assign next_grant = (slot_num_in_0_tvalid && slot_num_in_1_tvalid) ? ~last_grant
                                                                     : slot_num_in_1_tvalid;

  // Granted-channel views of the input streams.
  assign g_slot_tdata  = grant_ch ? slot_num_in_1_tdata  : slot_num_in_0_tdata;
  assign g_slot_tvalid = grant_ch ? slot_num_in_1_tvalid : slot_num_in_0_tvalid;
  assign g_data_tdata  = grant_ch ? data_in_1_tdata      : data_in_0_tdata;
  assign g_data_tlast  = grant_ch ? data_in_1_tlast      : data_in_0_tlast;
  assign g_data_tvalid = grant_ch ? data_in_1_tvalid     : data_in_0_tvalid;

  assign slot_hs      = (state == SLOT) && g_slot_tvalid && dp_slot_tready;
  assign data_last_hs = (state == DATA) && g_data_tvalid && g_data_tlast && dp_in_tready;

  // --------------------------------------------------------------------------
  // Input-side steering. Everything is gated by state so that reset (which
  // forces IDLE asynchronously) drops every valid/ready at once.
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path through
  // it leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dp_slot_tdata        = '0;
    dp_slot_tvalid       = 1'b0;
    slot_num_in_0_tready = 1'b0;
    slot_num_in_1_tready = 1'b0;
    dp_in_tdata          = '0;
    dp_in_tlast          = 1'b0;
    dp_in_tvalid         = 1'b0;
    data_in_0_tready     = 1'b0;
    data_in_1_tready     = 1'b0;
    if (state == SLOT) begin
      dp_slot_tdata  = g_slot_tdata;
      dp_slot_tvalid = g_slot_tvalid;
      if (grant_ch) slot_num_in_1_tready = dp_slot_tready;
      else          slot_num_in_0_tready = dp_slot_tready;
    end
    if (state == DATA) begin
      dp_in_tdata  = g_data_tdata;
      dp_in_tlast  = g_data_tlast;
      dp_in_tvalid = g_data_tvalid;
      if (grant_ch) data_in_1_tready = dp_in_tready;
      else          data_in_0_tready = dp_in_tready;
    end
  end

  // --------------------------------------------------------------------------
  // Scheduler FSM. A grant is only issued when the tag FIFO has room, so the
  // push on the later slot handshake can never overflow it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant_ch   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !fifo_full) begin
            grant_ch <= next_grant;
            state    <= SLOT;
          end
        end
        SLOT: begin
          if (slot_hs) state <= DATA;
        end
        DATA: begin
          if (data_last_hs) begin
            last_grant <= grant_ch;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tag FIFO: one entry per packet between slot handshake and output tlast.
  // --------------------------------------------------------------------------
  wn_phase_comp_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (slot_hs),
    .push_tag (grant_ch),
    .pop      (tag_pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Return path: the head tag picks the destination channel. With no tag the
  // datapath output is refused and flagged.
  // --------------------------------------------------------------------------
  always_comb begin
    dp_out_tready     = 1'b0;
    data_out_0_tdata  = '0;
    data_out_0_tlast  = 1'b0;
    data_out_0_tvalid = 1'b0;
    data_out_1_tdata  = '0;
    data_out_1_tlast  = 1'b0;
    data_out_1_tvalid = 1'b0;
    if (!fifo_empty) begin
      if (head_tag) begin
        data_out_1_tdata  = dp_out_tdata;
        data_out_1_tlast  = dp_out_tlast;
        data_out_1_tvalid = dp_out_tvalid;
        dp_out_tready     = data_out_1_tready;
      end else begin
        data_out_0_tdata  = dp_out_tdata;
        data_out_0_tlast  = dp_out_tlast;
        data_out_0_tvalid = dp_out_tvalid;
        dp_out_tready     = data_out_0_tready;
      end
    end
  end

  assign tag_pop     = dp_out_tvalid && dp_out_tready && dp_out_tlast;
  assign tag_err_set = fifo_empty && dp_out_tvalid;
  assign busy        = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         tag_err <= 1'b0;
    else if (tag_err_set) tag_err <= 1'b1;
  end

`ifdef PHC_SCHED_PKT_CNT_EN
  // Output packet counters (wrap naturally at 16 bits) and a count of
  // rising edges of tag_err.
  logic out0_last_hs;
  logic out1_last_hs;

  assign out0_last_hs = data_out_0_tvalid && data_out_0_tready && data_out_0_tlast;
  assign out1_last_hs = data_out_1_tvalid && data_out_1_tready && data_out_1_tlast;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
      drop_cnt  <= '0;
    end else begin
      if (out0_last_hs)             pkt_cnt_0 <= pkt_cnt_0 + 16'd1;
      if (out1_last_hs)             pkt_cnt_1 <= pkt_cnt_1 + 16'd1;
      if (tag_err_set && !tag_err)  drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wn_phase_comp_scheduler.sv
// ----------------------------------------------------------------------------
// tb_wn_phase_comp_scheduler
// Directed bench for wn_phase_comp_scheduler. The bench plays the sources,
// the sinks and an identity datapath (dp_in beats are replayed on dp_out in
// order). Inputs are driven just after the falling edge and observed 1 ns
// later, well before the rising edge.
// ----------------------------------------------------------------------------
module tb_wn_phase_comp_scheduler;

  localparam int DW = 32;
  localparam int SW = 8;

  typedef logic [63:0] word_q_t[$];

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic [SW-1:0] slot_num_in_0_tdata, slot_num_in_1_tdata, dp_slot_tdata;
  logic          slot_num_in_0_tvalid, slot_num_in_0_tready;
  logic          slot_num_in_1_tvalid, slot_num_in_1_tready;
  logic [DW-1:0] data_in_0_tdata, data_in_1_tdata, dp_in_tdata, dp_out_tdata;
  logic [DW-1:0] data_out_0_tdata, data_out_1_tdata;
  logic          data_in_0_tlast, data_in_0_tvalid, data_in_0_tready;
  logic          data_in_1_tlast, data_in_1_tvalid, data_in_1_tready;
  logic          dp_slot_tvalid, dp_slot_tready;
  logic          dp_in_tlast, dp_in_tvalid, dp_in_tready;
  logic          dp_out_tlast, dp_out_tvalid, dp_out_tready;
  logic          data_out_0_tlast, data_out_0_tvalid, data_out_0_tready;
  logic          data_out_1_tlast, data_out_1_tvalid, data_out_1_tready;
  logic          grant_ch, busy, tag_err;
`ifdef PHC_SCHED_PKT_CNT_EN
  logic [15:0]   pkt_cnt_0, pkt_cnt_1, drop_cnt;
`endif

  wn_phase_comp_scheduler dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .slot_num_in_0_tdata  (slot_num_in_0_tdata),
    .slot_num_in_0_tvalid (slot_num_in_0_tvalid),
    .slot_num_in_0_tready (slot_num_in_0_tready),
    .data_in_0_tdata      (data_in_0_tdata),
    .data_in_0_tlast      (data_in_0_tlast),
    .data_in_0_tvalid     (data_in_0_tvalid),
    .data_in_0_tready     (data_in_0_tready),
    .slot_num_in_1_tdata  (slot_num_in_1_tdata),
    .slot_num_in_1_tvalid (slot_num_in_1_tvalid),
    .slot_num_in_1_tready (slot_num_in_1_tready),
    .data_in_1_tdata      (data_in_1_tdata),
    .data_in_1_tlast      (data_in_1_tlast),
    .data_in_1_tvalid     (data_in_1_tvalid),
    .data_in_1_tready     (data_in_1_tready),
    .dp_slot_tdata        (dp_slot_tdata),
    .dp_slot_tvalid       (dp_slot_tvalid),
    .dp_slot_tready       (dp_slot_tready),
    .dp_in_tdata          (dp_in_tdata),
    .dp_in_tlast          (dp_in_tlast),
    .dp_in_tvalid         (dp_in_tvalid),
    .dp_in_tready         (dp_in_tready),
    .dp_out_tdata         (dp_out_tdata),
    .dp_out_tlast         (dp_out_tlast),
    .dp_out_tvalid        (dp_out_tvalid),
    .dp_out_tready        (dp_out_tready),
    .data_out_0_tdata     (data_out_0_tdata),
    .data_out_0_tlast     (data_out_0_tlast),
    .data_out_0_tvalid    (data_out_0_tvalid),
    .data_out_0_tready    (data_out_0_tready),
    .data_out_1_tdata     (data_out_1_tdata),
    .data_out_1_tlast     (data_out_1_tlast),
    .data_out_1_tvalid    (data_out_1_tvalid),
    .data_out_1_tready    (data_out_1_tready),
    .grant_ch             (grant_ch),
    .busy                 (busy),
    .tag_err              (tag_err)
`ifdef PHC_SCHED_PKT_CNT_EN
    ,
    .pkt_cnt_0            (pkt_cnt_0),
    .pkt_cnt_1            (pkt_cnt_1),
    .drop_cnt             (drop_cnt)
`endif
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input word_q_t got, input word_q_t exp);
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  // --------------------------------------------------------------------------
  // Source / sink / datapath models and logs
  // --------------------------------------------------------------------------
  logic [SW-1:0] slot_q0[$], slot_q1[$];
  logic [DW:0]   src_q0[$], src_q1[$], dp_q[$];   // {tlast, tdata}
  word_q_t       din_log, din_last_log, slot_log, out_log0, out_log1;
  word_q_t       exp_ch0, exp_ch1, empty_q;
  int            slot_cyc[$], first_hs_cyc[$], last_hs_cyc[$], pop_cyc[$];
  int            cyc, bp_idx;
  bit            dp_out_en, spur, bp_en, in_pkt, prev_stall;
  logic [DW-1:0] prev_data;
  int            out1_valid_seen, grant1_seen, mirror_err, stall_err;
  bit            rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic clear_all();
    slot_q0.delete(); slot_q1.delete(); src_q0.delete(); src_q1.delete(); dp_q.delete();
    din_log.delete(); din_last_log.delete(); slot_log.delete();
    out_log0.delete(); out_log1.delete(); exp_ch0.delete(); exp_ch1.delete();
    slot_cyc.delete(); first_hs_cyc.delete(); last_hs_cyc.delete(); pop_cyc.delete();
    cyc = 0; bp_idx = 0; dp_out_en = 1'b1; spur = 1'b0; bp_en = 1'b0;
    in_pkt = 1'b0; prev_stall = 1'b0; prev_data = '0;
    out1_valid_seen = 0; grant1_seen = 0; mirror_err = 0; stall_err = 0;
  endtask

  task automatic add_pkt(input bit ch, input logic [SW-1:0] slot,
                         input logic [DW-1:0] base, input int n);
    logic [DW:0] beat;
    if (ch) slot_q1.push_back(slot); else slot_q0.push_back(slot);
    for (int i = 0; i < n; i++) begin
      beat = {(i == n - 1), base + DW'(i)};
      if (ch) begin src_q1.push_back(beat); exp_ch1.push_back(64'(base + DW'(i))); end
      else    begin src_q0.push_back(beat); exp_ch0.push_back(64'(base + DW'(i))); end
    end
  endtask

  task automatic drive();
    slot_num_in_0_tvalid = 1'b0; slot_num_in_0_tdata = '0;
    slot_num_in_1_tvalid = 1'b0; slot_num_in_1_tdata = '0;
    data_in_0_tvalid = 1'b0; {data_in_0_tlast, data_in_0_tdata} = '0;
    data_in_1_tvalid = 1'b0; {data_in_1_tlast, data_in_1_tdata} = '0;
    if (slot_q0.size() > 0) begin slot_num_in_0_tvalid = 1'b1; slot_num_in_0_tdata = slot_q0[0]; end
    if (slot_q1.size() > 0) begin slot_num_in_1_tvalid = 1'b1; slot_num_in_1_tdata = slot_q1[0]; end
    if (src_q0.size() > 0) begin data_in_0_tvalid = 1'b1; {data_in_0_tlast, data_in_0_tdata} = src_q0[0]; end
    if (src_q1.size() > 0) begin data_in_1_tvalid = 1'b1; {data_in_1_tlast, data_in_1_tdata} = src_q1[0]; end
    dp_slot_tready    = 1'b1;
    dp_in_tready      = bp_en ? rdy_pat[bp_idx % 4] : 1'b1;
    data_out_0_tready = 1'b1;
    data_out_1_tready = 1'b1;
    dp_out_tvalid = 1'b0; {dp_out_tlast, dp_out_tdata} = '0;
    if (spur) begin
      dp_out_tvalid = 1'b1; dp_out_tlast = 1'b1; dp_out_tdata = 32'hDEAD_BEEF;
    end else if (dp_out_en && dp_q.size() > 0) begin
      dp_out_tvalid = 1'b1; {dp_out_tlast, dp_out_tdata} = dp_q[0];
    end
  endtask

  // Records every handshake that the coming rising edge will complete.
  task automatic observe();
    if (slot_num_in_0_tvalid && slot_num_in_0_tready) void'(slot_q0.pop_front());
    if (slot_num_in_1_tvalid && slot_num_in_1_tready) void'(slot_q1.pop_front());
    if (dp_slot_tvalid && dp_slot_tready) begin
      slot_log.push_back(64'(dp_slot_tdata));
      slot_cyc.push_back(cyc);
    end
    if (data_in_0_tvalid && data_in_0_tready) void'(src_q0.pop_front());
    if (data_in_1_tvalid && data_in_1_tready) void'(src_q1.pop_front());
    if (dp_out_tvalid && dp_out_tready) begin
      if (!spur) void'(dp_q.pop_front());
      if (dp_out_tlast) pop_cyc.push_back(cyc);
    end
    if (dp_in_tvalid && dp_in_tready) begin
      dp_q.push_back({dp_in_tlast, dp_in_tdata});
      din_log.push_back(64'(dp_in_tdata));
      din_last_log.push_back(64'(dp_in_tlast));
      if (!in_pkt) first_hs_cyc.push_back(cyc);
      if (dp_in_tlast) last_hs_cyc.push_back(cyc);
      in_pkt = !dp_in_tlast;
    end
    if (data_out_0_tvalid && data_out_0_tready) out_log0.push_back(64'(data_out_0_tdata));
    if (data_out_1_tvalid && data_out_1_tready) out_log1.push_back(64'(data_out_1_tdata));
    if (data_out_1_tvalid) out1_valid_seen++;
    if (grant_ch) grant1_seen++;
    if (dp_in_tvalid && !grant_ch && (data_in_0_tready !== dp_in_tready || data_in_1_tready))
      mirror_err++;
    if (prev_stall && dp_in_tdata !== prev_data) stall_err++;
    prev_stall = dp_in_tvalid && !dp_in_tready;
    prev_data  = dp_in_tdata;
  endtask

  task automatic cycle();
    drive();
    #1;
    observe();
    bp_idx++;
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    drive();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [12:0] ctrl_vec();
    return {dp_slot_tvalid, slot_num_in_0_tready, slot_num_in_1_tready,
            data_in_0_tready, data_in_1_tready, dp_in_tvalid, dp_in_tlast,
            dp_out_tready, data_out_0_tvalid, data_out_1_tvalid,
            grant_ch, busy, tag_err};
  endfunction

  function automatic logic any_tdata();
    return |{dp_slot_tdata, dp_in_tdata, data_out_0_tdata, data_out_1_tdata};
  endfunction

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  word_q_t exp_q;

  initial begin
    clear_all();
    drive();
    #2 reset_n = 1'b0;
    @(negedge clock);

    // Reset state while traffic is already presented.
    add_pkt(1'b0, 8'h01, 32'hA000_0000, 1);
    spur = 1'b1;
    drive();
    #1;
    check("rst_ctrl", 64'(ctrl_vec()), 64'd0);
    check("rst_tdata", 64'(any_tdata()), 64'd0);
    do_reset();

    // Channel 0 only: slot 1, 8 samples.
    add_pkt(1'b0, 8'h01, 32'h0001_0010, 8);
    for (int i = 0; i < 100 && out_log0.size() < 8; i++) cycle();
    exp_q = '{64'd1};
    check_q("t1_slot", slot_log, exp_q);
    check_q("t1_din", din_log, exp_ch0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i == 7));
    check_q("t1_last", din_last_log, exp_q);
    check_q("t1_out0", out_log0, exp_ch0);
    check_q("t1_out1", out_log1, empty_q);
    check("t1_out1_valid", 64'(out1_valid_seen), 64'd0);
    check("t1_grant1", 64'(grant1_seen), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);
`ifdef PHC_SCHED_PKT_CNT_EN
    check("t1_pkt_cnt_0", 64'(pkt_cnt_0), 64'd1);
    check("t1_pkt_cnt_1", 64'(pkt_cnt_1), 64'd0);
`endif

    // Both channels valid from reset: ch0 first, then ch1 after 2 idle cycles.
    do_reset();
    add_pkt(1'b0, 8'h03, 32'hB000_0000, 4);
    add_pkt(1'b1, 8'h07, 32'hC000_0000, 4);
    for (int i = 0; i < 100 && (out_log0.size() < 4 || out_log1.size() < 4); i++) cycle();
    exp_q = '{64'd3, 64'd7};
    check_q("t2_slot", slot_log, exp_q);
    check("t2_first_slot_cyc", 64'(slot_cyc.size() > 0 ? slot_cyc[0] : -1), 64'd1);
    exp_q = {exp_ch0, exp_ch1};
    check_q("t2_din", din_log, exp_q);
    check("t2_gap", 64'((first_hs_cyc.size() > 1 && last_hs_cyc.size() > 0)
                        ? first_hs_cyc[1] - last_hs_cyc[0] : -1), 64'd3);
    check_q("t2_out0", out_log0, exp_ch0);
    check_q("t2_out1", out_log1, exp_ch1);

    // Datapath backpressure 1,0,0,1 on dp_in_tready.
    do_reset();
    bp_en = 1'b1;
    add_pkt(1'b0, 8'h02, 32'hD000_0000, 6);
    for (int i = 0; i < 100 && out_log0.size() < 6; i++) cycle();
    check_q("t3_din", din_log, exp_ch0);
    check_q("t3_out0", out_log0, exp_ch0);
    check("t3_mirror", 64'(mirror_err), 64'd0);
    check("t3_stall_stable", 64'(stall_err), 64'd0);

    // Tag FIFO full: 4 packets outstanding, 5th must wait for one output tlast.
    do_reset();
    dp_out_en = 1'b0;
    add_pkt(1'b0, 8'd10, 32'hE000_0000, 2);
    add_pkt(1'b1, 8'd20, 32'hE100_0000, 2);
    add_pkt(1'b0, 8'd11, 32'hE010_0000, 2);
    add_pkt(1'b1, 8'd21, 32'hE110_0000, 2);
    add_pkt(1'b0, 8'd12, 32'hE020_0000, 2);
    repeat (30) cycle();
    drive();
    #1;
    check("t4_slots_held", 64'(slot_log.size()), 64'd4);
    check("t4_slot0_tready", 64'(slot_num_in_0_tready), 64'd0);
    check("t4_dp_slot_tvalid", 64'(dp_slot_tvalid), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    dp_out_en = 1'b1;
    for (int i = 0; i < 150 && (out_log0.size() < 6 || out_log1.size() < 4); i++) cycle();
    exp_q = '{64'd10, 64'd20, 64'd11, 64'd21, 64'd12};
    check_q("t4_slot", slot_log, exp_q);
    check("t4_grant_after_pop", 64'((slot_cyc.size() > 4 && pop_cyc.size() > 0)
                                    ? slot_cyc[4] - pop_cyc[0] : -1), 64'd2);
    check_q("t4_out0", out_log0, exp_ch0);
    check_q("t4_out1", out_log1, exp_ch1);

    // Spurious datapath output with the FIFO empty.
    do_reset();
    spur = 1'b1;
    drive();
    #1;
    check("t5_dp_out_tready", 64'(dp_out_tready), 64'd0);
    check("t5_out_valids", 64'({data_out_0_tvalid, data_out_1_tvalid}), 64'd0);
    check("t5_tag_err_before", 64'(tag_err), 64'd0);
    @(posedge clock);
    @(negedge clock);
    spur = 1'b0;
    drive();
    #1;
    check("t5_tag_err_set", 64'(tag_err), 64'd1);
    @(negedge clock);
    repeat (3) cycle();
    check("t5_tag_err_sticky", 64'(tag_err), 64'd1);
`ifdef PHC_SCHED_PKT_CNT_EN
    check("t5_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

    // Reset mid-packet at sample 3 of 8, then ch0 must win the next tie.
    do_reset();
    add_pkt(1'b0, 8'h05, 32'hF000_0000, 8);
    for (int i = 0; i < 50 && din_log.size() < 2; i++) cycle();
    drive();
    #1;
    check("t6_mid_valid", 64'(dp_in_tvalid), 64'd1);
    check("t6_mid_sample", 64'(dp_in_tdata), 64'hF000_0002);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_ctrl", 64'(ctrl_vec()), 64'd0);
    check("t6_async_tdata", 64'(any_tdata()), 64'd0);
    clear_all();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    add_pkt(1'b1, 8'h09, 32'h1100_0000, 1);
    add_pkt(1'b0, 8'h04, 32'h1000_0000, 1);
    for (int i = 0; i < 60 && (out_log0.size() < 1 || out_log1.size() < 1); i++) cycle();
    exp_q = '{64'd4, 64'd9};
    check_q("t6_slot", slot_log, exp_q);
    check_q("t6_out0", out_log0, exp_ch0);
    check_q("t6_out1", out_log1, exp_ch1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wn_phase_comp_scheduler.md
Name: wn_phase_comp_scheduler

Overview:
- Shares one phase-compensation datapath (params + pre-compensation chain) between two antenna streams, channel 0 and channel 1.
- Arbitrates per symbol packet, round-robin, and forwards the slot number of the granted channel.
- Passes that channel's samples through to tlast, then routes the datapath's output packets back to the owning channel.
- Sits between the per-antenna AXI-stream sources/sinks and the shared phase-compensation core.

Parameters:
- DATA_W, 32, sample width (imag[31:16], real[15:0]).
- SLOT_W, 8, slot number width.
- TAG_DEPTH, 4, maximum packets in flight inside the datapath (power of 2, ≥2).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- slot_num_in_0_tdata/tvalid/tready  in/in/out  SLOT_W/1/1  slot number, channel 0.
- data_in_0_tdata/tlast/tvalid/tready  in/in/in/out  DATA_W/1/1/1  samples, channel 0.
- slot_num_in_1_*, data_in_1_*  same as channel 0, for channel 1.
- dp_slot_tdata/tvalid/tready  out/out/in  SLOT_W/1/1  slot number to the datapath.
- dp_in_tdata/tlast/tvalid/tready  out/out/out/in  DATA_W/1/1/1  samples to the datapath.
- dp_out_tdata/tlast/tvalid/tready  in/in/in/out  DATA_W/1/1/1  compensated samples from the datapath.
- data_out_0_tdata/tlast/tvalid/tready  out/out/out/in  DATA_W/1/1/1  output, channel 0.
- data_out_1_*  same as data_out_0_*, for channel 1.
- grant_ch  out  1  channel currently owning the input side.
- busy  out  1  FSM is not IDLE, or the tag FIFO is non-empty.
- tag_err  out  1  sticky: dp_out_tvalid seen while the tag FIFO was empty.

Behaviour:
- Reset values:
  - FSM=IDLE, last_grant=1 (so channel 0 wins first), tag FIFO empty.
  - All tvalid/tready outputs 0; grant_ch=0, busy=0, tag_err=0; tdata outputs 0.
- FSM state IDLE:
  - Candidate = channel with slot_num_in_N_tvalid=1.
  - Both valid: grant the channel ≠ last_grant.
  - Grant only if the tag FIFO is not full; otherwise hold IDLE with nothing accepted.
  - On grant: register grant_ch, go to SLOT next cycle.
- FSM state SLOT:
  - dp_slot_tdata/tvalid = granted channel's slot_num; slot_num_in_<g>_tready = dp_slot_tready.
  - On handshake: push grant_ch into the tag FIFO, go to DATA.
  - Non-granted channel tready is held 0 throughout.
- FSM state DATA:
  - Combinational pass-through, zero latency: dp_in_* = data_in_<g>_*, data_in_<g>_tready = dp_in_tready.
  - Other channel's data tready = 0.
  - On a handshake with tlast=1: last_grant ← grant_ch, go to IDLE.
  - A packet is never preempted.
- Minimum turnaround is 2 idle cycles between packets on dp_in (IDLE→SLOT, SLOT handshake).
- Return path:
  - Head tag selects the destination: data_out_<tag>_* = dp_out_*, dp_out_tready = data_out_<tag>_tready.
  - Non-selected data_out tvalid = 0.
  - Pop the tag on a dp_out handshake with tlast=1.
- Tag FIFO empty:
  - dp_out_tready = 0, both data_out tvalid = 0.
  - If dp_out_tvalid=1, set tag_err (sticky until reset).
- Push and pop in the same cycle are both honoured; occupancy is unchanged. Full/empty use an occupancy counter of width clog2(TAG_DEPTH)+1.
- Reset mid-packet aborts immediately: FSM to IDLE, FIFO cleared. There is no partial-packet recovery; upstream must also be reset.
- Single-sample packets (tlast on the first beat) are legal.

Optional Feature:
- Macro: PHC_SCHED_PKT_CNT_EN.
- Defined:
  - Adds outputs pkt_cnt_0 and pkt_cnt_1, 16 bits each, reset to 0.
  - Each increments on a data_out_N tlast handshake and wraps 0xFFFF→0.
  - Adds output drop_cnt (16 bits), which increments each cycle tag_err is newly set.
- Not defined: the ports are absent; no counters are synthesized.

Decomposition:
- Package wn_phase_comp_sched_pkg holds:
  - enum sched_state_e {IDLE, SLOT, DATA};
  - typedef chan_t (1 bit);
  - localparams for the default widths and TAG_DEPTH.
- Sub-module wn_phase_comp_tag_fifo: synchronous FIFO of chan_t, depth TAG_DEPTH, with push/pop/full/empty and the occupancy counter. Its reset is the same async active-low reset_n.

Test Plan:
- Only channel 0 active:
  - Stimulus: slot 1, 8-sample packet, all treadys held 1.
  - Required: dp_slot_tdata=1, dp_in carries the 8 samples in order with tlast on the 8th, output appears only on data_out_0, data_out_1_tvalid stays 0, grant_ch=0 throughout.
- Both channels valid from reset:
  - Stimulus: ch0 slot 3, ch1 slot 7, 4 samples each.
  - Required: ch0 granted first; dp_slot sequence 3 then 7; the ch1 packet starts 2 cycles after ch0's tlast.
- Datapath backpressure:
  - Stimulus: dp_in_tready toggling 1,0,0,1…
  - Required: data_in_0_tready mirrors it exactly, no sample lost or duplicated, tdata stable while stalled.
- Tag FIFO full (TAG_DEPTH=4):
  - Stimulus: dp_out_tready side held off so 4 packets are outstanding; 5th slot presented.
  - Required: slot_num tready=0 until one dp_out tlast handshake, then the 5th packet is granted.
- Spurious output:
  - Stimulus: dp_out_tvalid=1 with the FIFO empty.
  - Required: tag_err=1 the next cycle and stays 1; dp_out_tready=0. With PHC_SCHED_PKT_CNT_EN, drop_cnt=1.
- Reset mid-packet:
  - Stimulus: reset_n low at sample 3 of 8.
  - Required: all tvalid/tready outputs 0 within the same cycle (async); busy=0; the next grant goes to channel 0.
